// File: rtl/cpu_sequencer_pkg.sv
// Shared phase encodings for the CPU instruction-cycle sequencer.
// The same values drive the debug LED mapping, so keep them stable.
package cpu_sequencer_pkg;

   localparam int PHASE_W = 3;

   typedef enum logic [PHASE_W-1:0] {
      PH_IDLE   = 3'd0,
      PH_FETCH  = 3'd1,
      PH_DECODE = 3'd2,
      PH_EXEC   = 3'd3,
      PH_INWAIT = 3'd4,
      PH_HALTED = 3'd5
   } phase_t;

endpackage

// File: rtl/cpu_sequencer_sync_edge.sv
// sync_edge: two-flop synchronizer for an asynchronous push-button,
// followed by a one-cycle rising-edge pulse.
module sync_edge (
   input  logic Clock,
   input  logic Reset,
   input  logic din,
   output logic pulse
);

   logic sync_1;
   logic sync_2;
   logic sync_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         sync_1 <= din;
         sync_2 <= sync_1;
         sync_q <= sync_2;
      end
   end

   assign pulse = sync_2 & ~sync_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer: paces FETCH/DECODE/EXEC from a Turbo-selectable
// prescaler and strobes the datapath. Optional macro SINGLE_STEP_EN adds Step pacing.
//
// state     | meaning
// ----------+-----------------------------------------------
// PH_IDLE   | after reset, waiting for the first tick
// PH_FETCH  | instruction latched at IP, IP incremented
// PH_DECODE | decode flags (Halt, NeedInput) are valid
// PH_EXEC   | decoded instruction executes
// PH_INWAIT | input instruction stalled until a Sample edge
// PH_HALTED | HALT executed; only Reset leaves
module cpu_sequencer
   import cpu_sequencer_pkg::*;
#(
   parameter int SLOW_DIV = 10000000,
   parameter int DIV_W    = 24
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               Turbo,
   input  logic               Sample,
   input  logic               NeedInput,
   input  logic               OutReq,
   input  logic               Halt,
`ifdef SINGLE_STEP_EN
   input  logic               StepMode,
   input  logic               Step,
`endif
   output logic               FetchEn,
   output logic               ExecEn,
   output logic               InLatch,
   output logic               Dval,
   output logic [PHASE_W-1:0] Phase
);

   localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(SLOW_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   logic             turbo_s1;
   logic             turbo_s;
   logic             turbo_q;
   logic             turbo_chg;
   logic [DIV_W-1:0] div_cnt;
   logic             div_tick;
   logic             cnt_hold;
   logic             tick;
   logic             sample_rise;
   logic             out_pend;
   phase_t           state;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         turbo_s1 <= 1'b0;
         turbo_s  <= 1'b0;
         turbo_q  <= 1'b0;
      end else begin
         turbo_s1 <= Turbo;
         turbo_s  <= turbo_s1;
         turbo_q  <= turbo_s;
      end
   end

   // A Turbo change restarts the prescaler so the next slow phase is full length.
   assign turbo_chg = turbo_s ^ turbo_q;
   assign div_tick  = !turbo_chg && (turbo_s || (div_cnt == DIV_TC));

   sync_edge u_sample_edge (
      .Clock (Clock),
      .Reset (Reset),
      .din   (Sample),
      .pulse (sample_rise)
   );

`ifdef SINGLE_STEP_EN
   logic step_rise;

   sync_edge u_step_edge (
      .Clock (Clock),
      .Reset (Reset),
      .din   (Step),
      .pulse (step_rise)
   );

   assign cnt_hold = StepMode;
   assign tick     = StepMode ? step_rise : div_tick;
`else
   assign cnt_hold = 1'b0;
   assign tick     = div_tick;
`endif

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         div_cnt <= '0;
      end else if (cnt_hold || turbo_chg || turbo_s || (div_cnt == DIV_TC)) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_ONE;
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state    <= PH_IDLE;
         FetchEn  <= 1'b0;
         ExecEn   <= 1'b0;
         InLatch  <= 1'b0;
         Dval     <= 1'b0;
         out_pend <= 1'b0;
      end else begin
         FetchEn <= 1'b0;
         ExecEn  <= 1'b0;
         InLatch <= 1'b0;
         Dval    <= 1'b0;
         case (state)
            PH_IDLE: begin
               if (tick) begin
                  state   <= PH_FETCH;
                  FetchEn <= 1'b1;
               end
            end
            PH_FETCH: begin
               if (tick) state <= PH_DECODE;
            end
            PH_DECODE: begin
               if (tick) begin
                  if (Halt) begin
                     state <= PH_HALTED;
                  end else if (NeedInput) begin
                     state <= PH_INWAIT;
                  end else begin
                     state  <= PH_EXEC;
                     ExecEn <= 1'b1;
                  end
               end
            end
            PH_INWAIT: begin
               if (sample_rise) begin
                  state   <= PH_EXEC;
                  ExecEn  <= 1'b1;
                  InLatch <= 1'b1;
               end
            end
            PH_EXEC: begin
               // OutReq is only meaningful in the ExecEn cycle; a one-cycle EXEC
               // (Turbo) leaves on that same cycle, hence the bypass.
               if (ExecEn) out_pend <= OutReq;
               if (tick) begin
                  state   <= PH_FETCH;
                  FetchEn <= 1'b1;
                  Dval    <= ExecEn ? OutReq : out_pend;
               end
            end
            PH_HALTED: state <= PH_HALTED;
            default:   state <= PH_IDLE;
         endcase
      end
   end

   assign Phase = state;

endmodule
